// File: rtl/sram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the 64Kx16 asynchronous SRAM controller:
//   - default SRAM geometry (also used by top and the bench)
//   - default read/write strobe lengths in clocks
//   - controller state encoding
//   - small helper for sizing the strobe wait counter
// ----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W   = 16;
    localparam int SRAM_DATA_W   = 16;
    localparam int DEF_RD_CYCLES = 2;
    localparam int DEF_WR_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_SETUP = 3'd1,
        ST_WR_PULSE = 3'd2,
        ST_WR_HOLD  = 3'd3,
        ST_RD_WAIT  = 3'd4
    } state_t;

    function automatic int max_cycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// ----------------------------------------------------------------------------
// sram_ctrl_if
// Command/response port between the stream/FIFO logic and sram_ctrl.
//   req_valid/req_ready : command handshake
//   req_we/addr/be/wdata: command payload (be bit0 = low byte, bit1 = high)
//   rsp_valid/rsp_rdata : one-cycle read-data pulse (no back-pressure)
//   dbg_state           : controller FSM state, observation only
//
// Handshake: a command transfers on a rising clock edge where both req_valid
// and req_ready are high. The payload must be stable while req_valid is high;
// req_ready never depends combinationally on req_valid. rsp_valid is a pulse
// with no ready: the requester must always be able to take read data.
// ----------------------------------------------------------------------------
interface sram_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    state_t            dbg_state;

    // Requester side (stream/FIFO logic).
    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, dbg_state
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, dbg_state
    );

endinterface

// File: rtl/sram_ctrl.sv
// ----------------------------------------------------------------------------
// sram_ctrl
// Single-word read/write controller for an asynchronous 64Kx16 SRAM.
// Generates active-low CE/OE/WE/LB/UB, address and data-bus timing. The
// data-bus tri-state lives outside: this block supplies drive data, drive
// enable and receives the sampled bus separately.
//
// Ports:
//   clk_100mhz  : clock
//   resetn      : asynchronous active-low reset
//   bus         : sram_ctrl_if.slave (command/response + debug state)
//   sram_a      : address pins
//   sram_d_out  : data to drive onto the bus
//   sram_d_oe   : 1 = FPGA drives the bus
//   sram_d_in   : bus value sampled from the pins
//   sram_ce/oe/we/lb/ub : active-low strobes
//
// Every output is a flop; nothing from the inputs reaches an output within
// the same cycle.
// ----------------------------------------------------------------------------
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int RD_CYCLES = DEF_RD_CYCLES,
    parameter int WR_CYCLES = DEF_WR_CYCLES
) (
    input  logic              clk_100mhz,
    input  logic              resetn,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d_out,
    output logic              sram_d_oe,
    input  logic [DATA_W-1:0] sram_d_in,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    output logic              sram_lb,
    output logic              sram_ub
);

    // Counter holds (cycles - 1) and the phase ends when it reaches zero.
    localparam int CNT_W = $clog2(max_cycles(RD_CYCLES, WR_CYCLES) + 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_be;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_dout;
    logic              r_doe;
    logic              r_ce;
    logic              r_oe;
    logic              r_wen;
    logic              r_lb;
    logic              r_ub;

    logic              w_accept;
    logic [DATA_W-1:0] w_be_mask;

    assign w_accept  = r_ready & bus.req_valid;
    assign w_be_mask = {{(DATA_W/2){r_be[1]}}, {(DATA_W/2){r_be[0]}}};

    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_be        <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_a         <= '0;
            r_dout      <= '0;
            r_doe       <= 1'b0;
            r_ce        <= 1'b1;
            r_oe        <= 1'b1;
            r_wen       <= 1'b1;
            r_lb        <= 1'b1;
            r_ub        <= 1'b1;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_a     <= bus.req_addr;
                        r_be    <= bus.req_be;
                        r_ce    <= 1'b0;
                        r_lb    <= ~bus.req_be[0];
                        r_ub    <= ~bus.req_be[1];
                        if (bus.req_we) begin
                            r_dout  <= bus.req_wdata;
                            r_doe   <= 1'b1;
                            r_state <= ST_WR_SETUP;
                        end else begin
                            // d_oe is already 0 in IDLE, so OE can fall here
                            // without ever overlapping our own bus drive.
                            r_oe    <= 1'b0;
                            r_cnt   <= CNT_W'(RD_CYCLES - 1);
                            r_state <= ST_RD_WAIT;
                        end
                    end else begin
                        // Also raises ready on the first clock after reset.
                        r_ready <= 1'b1;
                    end
                end

                ST_WR_SETUP: begin
                    r_wen   <= 1'b0;
                    r_cnt   <= CNT_W'(WR_CYCLES - 1);
                    r_state <= ST_WR_PULSE;
                end

                ST_WR_PULSE: begin
                    if (r_cnt == '0) begin
                        r_wen   <= 1'b1;
                        r_state <= ST_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_WR_HOLD: begin
                    // Address/data stay put through the WE rising edge; the
                    // bus is released together with CE/LB/UB.
                    r_doe   <= 1'b0;
                    r_ce    <= 1'b1;
                    r_lb    <= 1'b1;
                    r_ub    <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end

                ST_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata     <= sram_d_in & w_be_mask;
                        r_rsp_valid <= 1'b1;
                        r_oe        <= 1'b1;
                        r_ce        <= 1'b1;
                        r_lb        <= 1'b1;
                        r_ub        <= 1'b1;
                        r_ready     <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    r_doe   <= 1'b0;
                    r_ce    <= 1'b1;
                    r_oe    <= 1'b1;
                    r_wen   <= 1'b1;
                    r_lb    <= 1'b1;
                    r_ub    <= 1'b1;
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.dbg_state = r_state;

    assign sram_a     = r_a;
    assign sram_d_out = r_dout;
    assign sram_d_oe  = r_doe;
    assign sram_ce    = r_ce;
    assign sram_oe    = r_oe;
    assign sram_we    = r_wen;
    assign sram_lb    = r_lb;
    assign sram_ub    = r_ub;

endmodule

// File: tb/tb_sram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_ctrl
// Two controller instances share one clock/reset: index 0 uses the default
// strobe lengths (RD=2, WR=2), index 1 uses RD=1, WR=4. Each has its own
// behavioural SRAM. 'sel' routes the command driver to one instance.
// The reference model keeps word contents per instance and derives expected
// read data, response cycle and ready spacing from the cycle counts alone.
// ----------------------------------------------------------------------------
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk_100mhz = 1'b0;
    logic resetn;
    int   cyc = 0;

    always #5 clk_100mhz = ~clk_100mhz;
    always @(posedge clk_100mhz) cyc++;

    // ---------------- DUT wiring ----------------
    bit                      sel;
    logic                    tb_valid;
    logic                    tb_we;
    logic [15:0]             tb_addr;
    logic [1:0]              tb_be;
    logic [15:0]             tb_wdata;

    logic [1:0]              rdy;
    logic [1:0]              rsp_v;
    logic [1:0][15:0]        rsp_d;
    state_t                  dbg_st [2];

    logic [1:0][15:0]        sram_a;
    logic [1:0][15:0]        sram_d_out;
    logic [1:0][15:0]        sram_d_in;
    logic [1:0]              sram_d_oe;
    logic [1:0]              ce, oe, we, lb, ub;

    logic [15:0]             mem [2][65536];

    sram_ctrl_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].req_valid = tb_valid && (sel == g[0]);
        assign bus[g].req_we    = tb_we;
        assign bus[g].req_addr  = tb_addr;
        assign bus[g].req_be    = tb_be;
        assign bus[g].req_wdata = tb_wdata;
        assign rdy[g]           = bus[g].req_ready;
        assign rsp_v[g]         = bus[g].rsp_valid;
        assign rsp_d[g]         = bus[g].rsp_rdata;
        assign dbg_st[g]        = bus[g].dbg_state;

        sram_ctrl #(
            .ADDR_W    (16),
            .DATA_W    (16),
            .RD_CYCLES ((g == 0) ? 2 : 1),
            .WR_CYCLES ((g == 0) ? 2 : 4)
        ) u_dut (
            .clk_100mhz (clk_100mhz),
            .resetn     (resetn),
            .bus        (bus[g]),
            .sram_a     (sram_a[g]),
            .sram_d_out (sram_d_out[g]),
            .sram_d_oe  (sram_d_oe[g]),
            .sram_d_in  (sram_d_in[g]),
            .sram_ce    (ce[g]),
            .sram_oe    (oe[g]),
            .sram_we    (we[g]),
            .sram_lb    (lb[g]),
            .sram_ub    (ub[g])
        );

        // Asynchronous SRAM read: disabled lanes return junk so that the
        // controller's lane masking is observable.
        assign sram_d_in[g] = (!ce[g] && !oe[g]) ?
            {(ub[g] ? 8'hA5 : mem[g][sram_a[g]][15:8]),
             (lb[g] ? 8'h5A : mem[g][sram_a[g]][7:0])} : 16'hDEAD;
    end

    // SRAM write while CE and WE are low and the bus is driven.
    always @(negedge clk_100mhz) begin
        for (int g = 0; g < 2; g++) begin
            if (!ce[g] && !we[g] && sram_d_oe[g]) begin
                if (!lb[g]) mem[g][sram_a[g]][7:0]  <= sram_d_out[g][7:0];
                if (!ub[g]) mem[g][sram_a[g]][15:8] <= sram_d_out[g][15:8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          exp_t_q[$];
    logic [15:0] ref_mem [int];
    int          contention = 0;
    int          we_low_cnt = 0;
    int          last_acc   = 0;
    int          last_busy  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rd_of(input bit s);
        return s ? 1 : 2;
    endfunction

    function automatic int wr_of(input bit s);
        return s ? 4 : 2;
    endfunction

    function automatic logic [15:0] lane_bits(input logic [1:0] b);
        return (b[1] ? 16'hFF00 : 16'h0000) | (b[0] ? 16'h00FF : 16'h0000);
    endfunction

    always @(negedge clk_100mhz) begin
        for (int g = 0; g < 2; g++) begin
            if (sram_d_oe[g] && !oe[g]) contention++;
        end
        if (!we[sel]) we_low_cnt++;
        if (rsp_v[~sel]) check("stray_rsp_other_dut", 1, 0);
        if (rsp_v[sel]) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                check("rsp_data", rsp_d[sel], exp_q.pop_front());
                check("rsp_cycle", cyc, exp_t_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        tb_valid = 1'b0;
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    // Presents one command and waits until it is taken. With b2b set, the
    // previous command was followed immediately by this one, so the gap
    // between acceptances must equal the previous command's busy time.
    task automatic issue(input logic w, input logic [15:0] a, input logic [1:0] b,
                         input logic [15:0] d, input bit b2b);
        bit          got;
        int          k;
        int          key;
        logic [15:0] old;
        tb_valid = 1'b1;
        tb_we    = w;
        tb_addr  = a;
        tb_be    = b;
        tb_wdata = d;
        got      = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_100mhz);
            if (rdy[sel]) got = 1'b1;
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
            tb_valid = 1'b0;
            return;
        end
        k = cyc;
        if (b2b) check("ready_gap", k - last_acc, last_busy);
        key = (int'(sel) << 16) + int'(a);
        old = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
        if (w) begin
            ref_mem[key] = (old & ~lane_bits(b)) | (d & lane_bits(b));
            last_busy    = wr_of(sel) + 3;
        end else begin
            exp_q.push_back(old & lane_bits(b));
            exp_t_q.push_back(k + rd_of(sel) + 1);
            last_busy = rd_of(sel) + 1;
        end
        last_acc = k;
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic random_run(input int n, input logic [15:0] pool[8]);
        int gap;
        gap = 1;
        for (int i = 0; i < n; i++) begin
            issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                  2'($urandom_range(0, 3)), 16'($urandom), gap == 0);
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
        end
        idle(8);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] pool [8];
        int          base;
        bit          found;

        resetn   = 1'b0;
        sel      = 1'b0;
        tb_valid = 1'b0;
        tb_we    = 1'b0;
        tb_addr  = '0;
        tb_be    = '0;
        tb_wdata = '0;
        pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h0010; pool[3] = 16'h1234;
        for (int i = 4; i < 8; i++) pool[i] = 16'($urandom_range(16'h2000, 16'h6FFF));

        // Reset held for 5 clocks.
        repeat (5) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        check("rst_strobes0", {ce[0], oe[0], we[0], lb[0], ub[0]}, 5'h1F);
        check("rst_strobes1", {ce[1], oe[1], we[1], lb[1], ub[1]}, 5'h1F);
        check("rst_d_oe", sram_d_oe, 2'b00);
        check("rst_ready", rdy, 2'b00);
        check("rst_rsp_valid", rsp_v, 2'b00);
        check("rst_rdata", rsp_d[0], 16'h0000);
        check("rst_addr", sram_a[0], 16'h0000);
        check("rst_d_out", sram_d_out[0], 16'h0000);
        resetn = 1'b1;
        #1 check("ready_before_edge", rdy, 2'b00);
        @(negedge clk_100mhz);
        check("ready_after_release", rdy, 2'b11);
        check("state_idle_after_release", dbg_st[0], ST_IDLE);
        idle(1);

        // Default instance: write then read, WE low count.
        sel  = 1'b0;
        base = we_low_cnt;
        issue(1'b1, 16'h1234, 2'b11, 16'hA55A, 1'b0);
        idle(6);
        check("we_low_cycles_default", we_low_cnt - base, 2);
        issue(1'b0, 16'h1234, 2'b11, 16'h0000, 1'b0);
        idle(5);

        // Byte lanes.
        issue(1'b1, 16'h0010, 2'b11, 16'hFFFF, 1'b0);
        issue(1'b1, 16'h0010, 2'b10, 16'h1200, 1'b1);
        issue(1'b0, 16'h0010, 2'b11, 16'h0000, 1'b1);
        issue(1'b0, 16'h0010, 2'b01, 16'h0000, 1'b1);
        issue(1'b0, 16'h0010, 2'b00, 16'h0000, 1'b1);
        idle(5);

        // Back-to-back around the address wrap boundary.
        issue(1'b1, 16'hFFFF, 2'b11, 16'hC3C3, 1'b0);
        issue(1'b0, 16'hFFFF, 2'b11, 16'h0000, 1'b1);
        issue(1'b1, 16'h0000, 2'b11, 16'h3C3C, 1'b1);
        issue(1'b0, 16'h0000, 2'b11, 16'h0000, 1'b1);
        issue(1'b0, 16'hFFFF, 2'b10, 16'h0000, 1'b1);
        issue(1'b1, 16'hFFFF, 2'b01, 16'h0077, 1'b1);
        issue(1'b0, 16'hFFFF, 2'b11, 16'h0000, 1'b1);
        idle(5);

        // Random traffic over a small address pool, each word initialised.
        for (int i = 0; i < 8; i++) issue(1'b1, pool[i], 2'b11, 16'($urandom), i != 0);
        random_run(40, pool);

        // Reset during the write pulse.
        issue(1'b1, 16'h7777, 2'b11, 16'h1111, 1'b0);
        tb_valid = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_100mhz);
            if (!we[0]) found = 1'b1;
        end
        check("wr_pulse_seen", found, 1);
        #1 resetn = 1'b0;
        #1;
        check("midrst_strobes", {ce[0], oe[0], we[0], lb[0], ub[0]}, 5'h1F);
        check("midrst_d_oe", sram_d_oe[0], 0);
        check("midrst_ready", rdy[0], 0);
        repeat (3) @(negedge clk_100mhz);
        resetn = 1'b1;
        @(negedge clk_100mhz);
        check("midrst_ready_after", rdy[0], 1);
        check("midrst_state_idle", dbg_st[0], ST_IDLE);
        idle(1);
        issue(1'b0, pool[3], 2'b11, 16'h0000, 1'b0);
        idle(5);

        // Second instance: RD=1, WR=4.
        sel  = 1'b1;
        base = we_low_cnt;
        issue(1'b1, 16'h0042, 2'b11, 16'hBEEF, 1'b0);
        idle(10);
        check("we_low_cycles_sweep", we_low_cnt - base, 4);
        issue(1'b0, 16'h0042, 2'b11, 16'h0000, 1'b0);
        issue(1'b1, 16'hFFFF, 2'b11, 16'h1357, 1'b1);
        issue(1'b0, 16'hFFFF, 2'b11, 16'h0000, 1'b1);
        issue(1'b1, 16'h0000, 2'b11, 16'h2468, 1'b1);
        issue(1'b0, 16'h0000, 2'b01, 16'h0000, 1'b1);
        issue(1'b0, 16'h0042, 2'b10, 16'h0000, 1'b1);
        idle(5);
        for (int i = 0; i < 8; i++) issue(1'b1, pool[i], 2'b11, 16'($urandom), i != 0);
        random_run(30, pool);

        check("rsp_drain", exp_q.size(), 0);
        check("no_bus_contention", contention, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Request/response controller for the on-board 64K×16 asynchronous SRAM. Accepts single-word read/write commands from the stream/FIFO logic on a valid/ready port and generates the active-low SRAM strobe, address and data-bus timing seen on the `top` SRAM pins. Sits directly upstream of the SRAM pins and the `sim_sram` model. Tri-state buffering of the data bus lives in `top`; this block supplies output data, output enable and input data separately.

## Interface
Parameters:
- `ADDR_W`, 16, SRAM word address width.
- `DATA_W`, 16, SRAM data width (two byte lanes).
- `RD_CYCLES`, 2, clocks with OE low before data capture; legal range ≥1.
- `WR_CYCLES`, 2, clocks with WE low per write; legal range ≥1.

Ports:
- `clk_100mhz`  in  1  system clock; the block's only clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  controller idle; a command is accepted when `req_valid & req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_be`  in  2  byte enables; bit0 = low byte (LB), bit1 = high byte (UB).
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle pulse carrying read data.
- `rsp_rdata`  out  DATA_W  read data; disabled byte lanes are 0.
- `sram_a`  out  ADDR_W  address pins.
- `sram_d_out`  out  DATA_W  data to drive.
- `sram_d_oe`  out  1  1 = FPGA drives the data bus.
- `sram_d_in`  in  DATA_W  data bus sampled from the pins.
- `sram_ce`, `sram_oe`, `sram_we`, `sram_lb`, `sram_ub`  out  1 each  active-low strobes.

## Operation
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT.
- IDLE: `req_ready`=1 and all strobes high. On accept, the block latches addr, be, wdata and we, drops `req_ready`, and goes to WR_SETUP (write) or RD_WAIT (read).
- WR_SETUP (1 cycle): `sram_a` valid, `sram_ce`=0, `sram_lb`/`sram_ub` = ~be, `sram_d_oe`=1, `sram_we`=1.
- WR_PULSE (WR_CYCLES cycles): as WR_SETUP, with `sram_we`=0.
- WR_HOLD (1 cycle): `sram_we`=1. Address, data and `d_oe` are held, then the state returns to IDLE.
- RD_WAIT (RD_CYCLES cycles): `sram_ce`=0, `sram_oe`=0, `sram_lb`/`sram_ub` = ~be, `sram_d_oe`=0. On the last cycle the block registers `sram_d_in` masked by be into `rsp_rdata` and goes to IDLE.
- A down-counter sized for max(RD_CYCLES, WR_CYCLES) times WR_PULSE and RD_WAIT. It is loaded on state entry.
- be=2'b00: the full cycle still runs with both lane strobes high. A read returns 0 and still pulses `rsp_valid`.
- Bus-contention rule: `sram_d_oe`=1 and `sram_oe`=0 are never asserted in the same cycle. The mandatory IDLE cycle between commands guarantees ≥1 cycle of bus turnaround.
- `sram_a` and `sram_d_out` hold their last values in IDLE; no glitch requirement applies in IDLE.

## Timing
- Reset values (applied asynchronously while `resetn`=0):
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0.
  - `sram_a`=0, `sram_d_out`=0, `sram_d_oe`=0.
  - all strobes =1.
  - state = IDLE; `req_ready` rises on the first clock after release.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Write: accept at edge T. Setup T+1, WE low T+2..T+1+WR_CYCLES, hold next cycle, IDLE at T+WR_CYCLES+3. Default: next accept possible at T+5.
- Read: accept at T. OE low T+1..T+RD_CYCLES. `rsp_valid` is high during cycle T+RD_CYCLES+1, which is also IDLE. A new command may be accepted in that same cycle. Default: read latency 3, read throughput one per 3 cycles.
- Reset asserted mid-operation: strobes go inactive and `d_oe`=0 immediately. The pending command is dropped and no `rsp_valid` is produced.
- `req_*` inputs are ignored whenever `req_ready`=0.

## Structure
- Shared package `sram_ctrl_pkg`:
  - state encoding constants;
  - default RD_CYCLES/WR_CYCLES;
  - the ADDR_W/DATA_W defaults, which are also used by `top` and the bench.
- Single flat module. The wait counter is small enough to stay inline, so no sub-module.

## Test plan
- Reset: hold `resetn`=0 for 5 clocks → all strobes 1, `sram_d_oe`=0, `req_ready`=0; `req_ready`=1 one clock after release.
- Write then read, using the `sim_sram` model: write 0xA55A to 0x1234 with be=11, then read 0x1234 → `rsp_rdata`=0xA55A. `rsp_valid` arrives 3 cycles after the read is accepted; WE is low for exactly 2 cycles.
- Byte lanes:
  - write 0xFFFF to 0x0010, then write 0x1200 with be=10 → read returns 0x12FF;
  - a read with be=01 returns 0x00FF.
- Back-to-back: hold `req_valid` high with alternating write/read to 0xFFFF (wrap boundary) and 0x0000. Check `req_ready` timing as specified, no cycle with `sram_d_oe`=1 & `sram_oe`=0, and correct data.
- Reset mid-write: assert `resetn`=0 during WR_PULSE → `sram_we`/`sram_ce` go high before the next clock edge. After release, the controller is in IDLE and no `rsp_valid` is produced.
- Parameter sweep: RD_CYCLES=1, WR_CYCLES=4 → read latency 2, write busy 7 cycles, data correct.
